// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back bundle for the scoreboarded register file.
// master = pipeline side, slave = register file.
interface regfile_scoreboard_if #(
  parameter int D_SIZE = 32,
  parameter int R_SIZE = 3
);
  logic              wb_en;
  logic [R_SIZE-1:0] wb_dest;
  logic [D_SIZE-1:0] wb_data;
  logic [R_SIZE-1:0] rd_addr_1;
  logic [R_SIZE-1:0] rd_addr_2;
  logic [D_SIZE-1:0] rd_data_1;
  logic [D_SIZE-1:0] rd_data_2;
  logic              rd_ready_1;
  logic              rd_ready_2;
  logic              iss_en;
  logic [R_SIZE-1:0] iss_dest;
  logic              iss_stall;
  logic              err_underflow;

  modport master (
    output wb_en, wb_dest, wb_data,
    output rd_addr_1, rd_addr_2,
    output iss_en, iss_dest,
    input  rd_data_1, rd_data_2,
    input  rd_ready_1, rd_ready_2,
    input  iss_stall, err_underflow
  );

  modport slave (
    input  wb_en, wb_dest, wb_data,
    input  rd_addr_1, rd_addr_2,
    input  iss_en, iss_dest,
    output rd_data_1, rd_data_2,
    output rd_ready_1, rd_ready_2,
    output iss_stall, err_underflow
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters.
// Define REGFILE_BYPASS_EN for same-cycle write-back forwarding.
module regfile_scoreboard #(
  parameter int D_SIZE   = 32,
  parameter int NUM_REGS = 8,
  parameter int R_SIZE   = 3,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 0
) (
  input logic clk,
  input logic reset,
  regfile_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [D_SIZE-1:0] regs_q [NUM_REGS];
  logic [D_SIZE-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
  logic              err_q;
  logic              err_d;

  logic wb_ok;
  logic iss_ok;
  logic stall;

  function automatic logic is_zero(
    input logic [R_SIZE-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wb_ok  = bus.wb_en && !is_zero(bus.wb_dest);
  assign stall  = !is_zero(bus.iss_dest) &&
                  (cnt_q[bus.iss_dest] == CNT_MAX);
  assign iss_ok = bus.iss_en && !stall &&
                  !is_zero(bus.iss_dest);

  assign bus.iss_stall     = stall;
  assign bus.err_underflow = err_q;

  // A same-register issue and write-back cancel out.
  always_comb begin
    logic inc;
    logic dec;
    regs_d = regs_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (wb_ok) begin
      regs_d[bus.wb_dest] = bus.wb_data;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      inc = iss_ok && (bus.iss_dest == R_SIZE'(i));
      dec = wb_ok  && (bus.wb_dest  == R_SIZE'(i));
      unique case (1'b1)
        (inc && !dec): cnt_d[i] = cnt_q[i] + CNT_ONE;
        (dec && !inc): begin
          if (cnt_q[i] == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit_1;
  logic hit_2;

  assign hit_1 = wb_ok && (bus.wb_dest == bus.rd_addr_1);
  assign hit_2 = wb_ok && (bus.wb_dest == bus.rd_addr_2);

  // Ready early when the last outstanding write lands now.
  assign bus.rd_data_1 =
    is_zero(bus.rd_addr_1) ? '0          :
    hit_1                  ? bus.wb_data :
                             regs_q[bus.rd_addr_1];
  assign bus.rd_data_2 =
    is_zero(bus.rd_addr_2) ? '0          :
    hit_2                  ? bus.wb_data :
                             regs_q[bus.rd_addr_2];
  assign bus.rd_ready_1 =
    is_zero(bus.rd_addr_1)           ||
    (cnt_q[bus.rd_addr_1] == '0)     ||
    (hit_1 && (cnt_q[bus.rd_addr_1] == CNT_ONE));
  assign bus.rd_ready_2 =
    is_zero(bus.rd_addr_2)           ||
    (cnt_q[bus.rd_addr_2] == '0)     ||
    (hit_2 && (cnt_q[bus.rd_addr_2] == CNT_ONE));
`else
  assign bus.rd_data_1 =
    is_zero(bus.rd_addr_1) ? '0 : regs_q[bus.rd_addr_1];
  assign bus.rd_data_2 =
    is_zero(bus.rd_addr_2) ? '0 : regs_q[bus.rd_addr_2];
  assign bus.rd_ready_1 =
    is_zero(bus.rd_addr_1) ||
    (cnt_q[bus.rd_addr_1] == '0);
  assign bus.rd_ready_2 =
    is_zero(bus.rd_addr_2) ||
    (cnt_q[bus.rd_addr_2] == '0);
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed table, reset,
// zero-register instance and a randomized model comparison.
module tb_regfile_scoreboard;

  localparam int DS   = 32;
  localparam int RS   = 3;
  localparam int NR   = 8;
  localparam int CW   = 2;
  localparam int MAXC = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.D_SIZE(DS), .R_SIZE(RS)) bus();
  regfile_scoreboard_if #(.D_SIZE(DS), .R_SIZE(RS)) bz();

  regfile_scoreboard #(
    .D_SIZE(DS), .NUM_REGS(NR), .R_SIZE(RS),
    .CNT_W(CW), .ZERO_REG(0)
  ) u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

  regfile_scoreboard #(
    .D_SIZE(DS), .NUM_REGS(NR), .R_SIZE(RS),
    .CNT_W(CW), .ZERO_REG(1)
  ) u_zr (.clk(clk), .reset(reset), .bus(bz.slave));

  int total = 0;
  int bad   = 0;

  // Behavioural model: values and outstanding-write counts.
  logic [31:0] m_reg [NR];
  int          m_cnt [NR];
  bit          m_err;

  bit          c_we, c_ie;
  int          c_wd, c_id;
  logic [31:0] c_wdat;

  typedef struct {
    bit we; int wd; logic [31:0] wdat;
    bit ie; int id; int a1; int a2;
    logic [31:0] d1; logic [31:0] d2;
    bit r1; bit r2; bit st; bit er;
  } vec_t;

  vec_t tv[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  // Issue counted first so a same-register pair nets to zero.
  function automatic void m_step(bit we, int wd,
      logic [31:0] wdat, bit ie, int id);
    if (ie && m_cnt[id] < MAXC) m_cnt[id]++;
    if (we) begin
      m_reg[wd] = wdat;
      if (m_cnt[wd] > 0) m_cnt[wd]--;
      else m_err = 1'b1;
    end
  endfunction

  function automatic logic [31:0] m_data(int a);
    if (BYP && c_we && c_wd == a) return c_wdat;
    return m_reg[a];
  endfunction

  function automatic bit m_ready(int a);
    if (m_cnt[a] == 0) return 1'b1;
    return BYP && c_we && c_wd == a && m_cnt[a] == 1;
  endfunction

  task automatic set_in(bit we, int wd, logic [31:0] wdat,
      bit ie, int id, int a1, int a2);
    c_we = we; c_wd = wd; c_wdat = wdat;
    c_ie = ie; c_id = id;
    bus.wb_en     = we;
    bus.wb_dest   = RS'(wd);
    bus.wb_data   = wdat;
    bus.iss_en    = ie;
    bus.iss_dest  = RS'(id);
    bus.rd_addr_1 = RS'(a1);
    bus.rd_addr_2 = RS'(a2);
  endtask

  task automatic set_z(bit we, int wd, logic [31:0] wdat,
      bit ie, int id, int a1, int a2);
    bz.wb_en     = we;
    bz.wb_dest   = RS'(wd);
    bz.wb_data   = wdat;
    bz.iss_en    = ie;
    bz.iss_dest  = RS'(id);
    bz.rd_addr_1 = RS'(a1);
    bz.rd_addr_2 = RS'(a2);
  endtask

  task automatic step();
    @(posedge clk);
    m_step(c_we, c_wd, c_wdat, c_ie, c_id);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".d1"}, bus.rd_data_1,
        m_data(int'(bus.rd_addr_1)));
    chk({tag, ".d2"}, bus.rd_data_2,
        m_data(int'(bus.rd_addr_2)));
    chk({tag, ".r1"}, 32'(bus.rd_ready_1),
        32'(m_ready(int'(bus.rd_addr_1))));
    chk({tag, ".r2"}, 32'(bus.rd_ready_2),
        32'(m_ready(int'(bus.rd_addr_2))));
    chk({tag, ".st"}, 32'(bus.iss_stall),
        32'(m_cnt[c_id] == MAXC));
    chk({tag, ".er"}, 32'(bus.err_underflow),
        32'(m_err));
  endtask

  function automatic vec_t mk(bit we, int wd,
      logic [31:0] wdat, bit ie, int id, int a1, int a2,
      logic [31:0] d1, logic [31:0] d2,
      bit r1, bit r2, bit st, bit er);
    vec_t v;
    v.we = we; v.wd = wd; v.wdat = wdat;
    v.ie = ie; v.id = id; v.a1 = a1; v.a2 = a2;
    v.d1 = d1; v.d2 = d2; v.r1 = r1; v.r2 = r2;
    v.st = st; v.er = er;
    return v;
  endfunction

  initial begin
    logic [31:0] h1, h4, h6, h6b, ha5;
    h1  = 32'h12345678;
    h4  = 32'h00000044;
    h6  = 32'h00000066;
    h6b = 32'h00000067;
    ha5 = 32'hA5A5A5A5;

    // Expected combinational outputs before each edge.
    tv.push_back(mk(0,0,0,   1,2, 2,2, 0,0, 1,1,0,0));
    tv.push_back(mk(0,0,0,   0,2, 2,3, 0,0, 0,1,0,0));
    tv.push_back(mk(1,2,h1,  0,2, 2,3, BYP?h1:0,0,
                    BYP,1,0,0));
    tv.push_back(mk(0,0,0,   0,2, 2,2, h1,h1, 1,1,0,0));
    tv.push_back(mk(0,0,0,   1,4, 4,2, 0,h1, 1,1,0,0));
    tv.push_back(mk(0,0,0,   1,4, 4,2, 0,h1, 0,1,0,0));
    tv.push_back(mk(0,0,0,   1,4, 4,2, 0,h1, 0,1,0,0));
    tv.push_back(mk(0,0,0,   1,4, 4,2, 0,h1, 0,1,1,0));
    tv.push_back(mk(1,4,h4,  0,4, 4,4, BYP?h4:0,
                    BYP?h4:0, 0,0,1,0));
    tv.push_back(mk(0,0,0,   0,4, 4,2, h4,h1, 0,1,0,0));
    tv.push_back(mk(0,0,0,   1,6, 6,4, 0,h4, 1,0,0,0));
    tv.push_back(mk(1,6,h6,  1,6, 6,6, BYP?h6:0,
                    BYP?h6:0, BYP,BYP,0,0));
    tv.push_back(mk(0,0,0,   0,6, 6,4, h6,h4, 0,0,0,0));
    tv.push_back(mk(1,1,5,   0,0, 1,6, BYP?5:0,h6,
                    1,0,0,0));
    tv.push_back(mk(0,0,0,   0,0, 1,6, 5,h6, 1,0,0,1));
    tv.push_back(mk(1,6,h6b, 0,0, 6,1, BYP?h6b:h6,5,
                    BYP,1,0,1));
    tv.push_back(mk(0,0,0,   1,7, 6,7, h6b,0, 1,1,0,1));
    tv.push_back(mk(1,7,ha5, 0,7, 7,6, BYP?ha5:0,h6b,
                    BYP,1,0,1));
    tv.push_back(mk(0,0,0,   0,7, 7,7, ha5,ha5, 1,1,0,1));

    reset = 1'b1;
    set_in(0,0,0,0,0,0,0);
    set_z(0,0,0,0,0,0,0);
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (tv[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      set_in(tv[i].we, tv[i].wd, tv[i].wdat,
             tv[i].ie, tv[i].id, tv[i].a1, tv[i].a2);
      #2;
      chk({t, ".d1"}, bus.rd_data_1, tv[i].d1);
      chk({t, ".d2"}, bus.rd_data_2, tv[i].d2);
      chk({t, ".r1"}, 32'(bus.rd_ready_1), 32'(tv[i].r1));
      chk({t, ".r2"}, 32'(bus.rd_ready_2), 32'(tv[i].r2));
      chk({t, ".st"}, 32'(bus.iss_stall), 32'(tv[i].st));
      chk({t, ".er"}, 32'(bus.err_underflow),
          32'(tv[i].er));
      @(posedge clk);
      #1;
    end

    // Mid-run asynchronous reset discards data and counts.
    set_in(1,3,32'hDEADBEEF, 1,5, 3,5);
    @(posedge clk);
    #1 set_in(0,0,0, 0,5, 3,5);
    #1;
    chk("pre_rst.d1", bus.rd_data_1, 32'hDEADBEEF);
    chk("pre_rst.r2", 32'(bus.rd_ready_2), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("rst.d1", bus.rd_data_1, 32'd0);
    chk("rst.d2", bus.rd_data_2, 32'd0);
    chk("rst.r1", 32'(bus.rd_ready_1), 32'd1);
    chk("rst.r2", 32'(bus.rd_ready_2), 32'd1);
    chk("rst.st", 32'(bus.iss_stall), 32'd0);
    chk("rst.er", 32'(bus.err_underflow), 32'd0);
    set_in(0,0,0, 1,5, 3,5);
    @(posedge clk);
    #1 reset = 1'b0;
    set_in(0,0,0, 0,5, 3,5);
    #1;
    chk("post_rst.d1", bus.rd_data_1, 32'd0);
    chk("post_rst.r2", 32'(bus.rd_ready_2), 32'd1);
    chk("post_rst.er", 32'(bus.err_underflow), 32'd0);
    m_reset();
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit we, ie;
      if (n == 1500) begin
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
      end
      we = ($urandom_range(0, 9) < 4);
      ie = ($urandom_range(0, 9) < 6);
      set_in(we, $urandom_range(0, NR-1), $urandom,
             ie, $urandom_range(0, NR-1),
             $urandom_range(0, NR-1),
             $urandom_range(0, NR-1));
      #2;
      check_model($sformatf("rnd%0d", n));
      step();
    end
    set_in(0,0,0,0,0,0,0);

    // Hard-wired zero register instance.
    set_z(1,0,32'hFF, 0,0, 0,0);
    #2;
    chk("z.wr.d1", bz.rd_data_1, 32'd0);
    chk("z.wr.r1", 32'(bz.rd_ready_1), 32'd1);
    @(posedge clk);
    #1 set_z(0,0,0, 0,0, 0,0);
    #1;
    chk("z.rd.d1", bz.rd_data_1, 32'd0);
    chk("z.rd.d2", bz.rd_data_2, 32'd0);
    chk("z.rd.er", 32'(bz.err_underflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      set_z(0,0,0, 1,0, 0,0);
      #1;
      chk($sformatf("z.iss%0d.st", k),
          32'(bz.iss_stall), 32'd0);
      chk($sformatf("z.iss%0d.r1", k),
          32'(bz.rd_ready_1), 32'd1);
      @(posedge clk);
      #1;
    end
    set_z(1,0,32'h1, 0,0, 0,1);
    @(posedge clk);
    #1 set_z(1,1,32'h11, 0,0, 1,0);
    #1;
    chk("z.wb0.er", 32'(bz.err_underflow), 32'd0);
    @(posedge clk);
    #1 set_z(0,0,0, 0,0, 1,0);
    #1;
    chk("z.r1.d1", bz.rd_data_1, 32'h11);
    chk("z.r1.er", 32'(bz.err_underflow), 32'd1);
    chk("z.r0.d2", bz.rd_data_2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
